// File: rtl/ofm_if.sv
// ofm_if: PE-result input, OFM memory write and tile status signals of ofm_writer
interface ofm_if #(parameter int ADDR_W = 8);
   logic              start;
   logic              relu_en;
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_ready;
   logic              mem_busy;
   logic              wr;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [7:0]        count;
   logic              done;
   modport master (
      output start, relu_en, in_valid, in_data, mem_busy,
      input  in_ready, wr, wr_addr, wr_data, count, done
   );
   modport slave (
      input  start, relu_en, in_valid, in_data, mem_busy,
      output in_ready, wr, wr_addr, wr_data, count, done
   );
endinterface

// File: rtl/ofm_writer.sv
// ofm_writer: per-lane ReLU, 2-deep FIFO and sequential OFM writes; done after NUM_WORDS words
module ofm_writer #(
   parameter int ADDR_W    = 8,
   parameter int NUM_WORDS = 16,
   parameter int BASE_ADDR = 0
) (
   input logic   clk,
   input logic   rst,
   ofm_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            r_state, w_next;
   logic [31:0]       r_fifo [2];
   logic              r_rd, r_wp;
   logic [1:0]        r_occ;
   logic [ADDR_W-1:0] r_ptr, r_wr_addr;
   logic [31:0]       r_wr_data, w_proc;
   logic [7:0]        r_count;
   logic              r_wr, r_done;
   logic              w_run, w_push, w_pop, w_last, w_start;

   for (genvar g = 0; g < 4; g++) begin : g_relu
      assign w_proc[8*g +: 8] = (bus.relu_en && bus.in_data[8*g+7]) ? 8'h00 : bus.in_data[8*g +: 8];
   end

   assign w_run        = r_state == RUN;
   assign bus.in_ready = w_run && r_occ != 2'd2;
   assign w_push       = bus.in_valid && bus.in_ready;
   // Only stored words are popped, so a word always spends at least one cycle in the FIFO
   assign w_pop        = w_run && r_occ != 2'd0 && !bus.mem_busy;
   assign w_last       = w_pop && r_count == 8'(NUM_WORDS - 1);
   assign w_start      = bus.start && !w_run;

   always_comb w_next = w_start ? RUN : w_last ? DONE : r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_wr      <= 1'b0;
         r_wr_addr <= ADDR_W'(BASE_ADDR);
         r_wr_data <= '0;
         r_ptr     <= ADDR_W'(BASE_ADDR);
         r_count   <= '0;
         r_done    <= 1'b0;
         r_occ     <= '0;
         r_rd      <= 1'b0;
         r_wp      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wr    <= w_pop;
         r_occ   <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
         if (w_push) r_wp <= ~r_wp;
         if (w_pop) begin
            r_wr_data <= r_fifo[r_rd];
            r_wr_addr <= r_ptr;
            r_ptr     <= r_ptr + 1'b1;
            r_count   <= r_count + 8'd1;
            r_rd      <= ~r_rd;
         end
         if (w_last) r_done <= 1'b1;
         if (w_start) begin
            r_ptr   <= ADDR_W'(BASE_ADDR);
            r_count <= '0;
            r_done  <= 1'b0;
            r_occ   <= '0;
            r_rd    <= 1'b0;
            r_wp    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wp] <= w_proc;
   end

   assign bus.wr      = r_wr;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.count   = r_count;
   assign bus.done    = r_done;
endmodule

// File: tb/tb_ofm_writer.sv
// tb_ofm_writer: directed cycle-by-cycle checks of ofm_writer (main tile, ReLU, backpressure, wrap, reset, DONE)
module tb_ofm_writer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ofm_if #(.ADDR_W(8)) ab ();
   ofm_if #(.ADDR_W(4)) wb ();

   ofm_writer #(.ADDR_W(8), .NUM_WORDS(4), .BASE_ADDR(8'h10)) u_a (.clk(clk), .rst(rst), .bus(ab.slave));
   ofm_writer #(.ADDR_W(4), .NUM_WORDS(4), .BASE_ADDR(14))    u_w (.clk(clk), .rst(rst), .bus(wb.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wr(input string tag, input logic [31:0] data, input logic [7:0] addr, input logic [7:0] cnt);
      check({tag, "_wr"}, 32'(ab.wr), 32'd1);
      check({tag, "_data"}, ab.wr_data, data);
      check({tag, "_addr"}, 32'(ab.wr_addr), 32'(addr));
      check({tag, "_count"}, 32'(ab.count), 32'(cnt));
   endtask

   logic [31:0] d [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
   logic [31:0] e [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
   logic [3:0]  wrap_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

   initial begin
      ab.start = 0; ab.relu_en = 0; ab.in_valid = 0; ab.in_data = 0; ab.mem_busy = 0;
      wb.start = 0; wb.relu_en = 0; wb.in_valid = 0; wb.in_data = 0; wb.mem_busy = 0;
      tick();
      tick();
      rst = 0;
      check("rst_wr", 32'(ab.wr), 0);
      check("rst_addr", 32'(ab.wr_addr), 32'h10);
      check("rst_data", ab.wr_data, 0);
      check("rst_count", 32'(ab.count), 0);
      check("rst_done", 32'(ab.done), 0);
      check("rst_ready", 32'(ab.in_ready), 0);
      check("rst_waddr", 32'(wb.wr_addr), 14);

      // back-to-back tile of 4 words
      ab.start = 1; tick(); ab.start = 0;
      check("t1_ready", 32'(ab.in_ready), 1);
      for (int i = 0; i < 4; i++) begin
         ab.in_valid = 1; ab.in_data = d[i];
         tick();
         if (i == 0) check("t1_nowr", 32'(ab.wr), 0);
         else check_wr("t1", d[i-1], 8'(8'h10 + i - 1), 8'(i));
         if (i == 3) check("t1_notdone", 32'(ab.done), 0);
      end
      ab.in_valid = 0;
      tick();
      check_wr("t1_last", d[3], 8'h13, 8'd4);
      check("t1_done", 32'(ab.done), 1);
      check("t1_ready_done", 32'(ab.in_ready), 0);

      // DONE ignores input
      ab.in_valid = 1; ab.in_data = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t6_wr", 32'(ab.wr), 0);
         check("t6_ready", 32'(ab.in_ready), 0);
         check("t6_done", 32'(ab.done), 1);
      end
      check("t6_hold", ab.wr_data, d[3]);
      ab.in_valid = 0; ab.start = 1; tick(); ab.start = 0;
      check("t6_done_clr", 32'(ab.done), 0);
      check("t6_count_clr", 32'(ab.count), 0);
      check("t6_ready", 32'(ab.in_ready), 1);

      // backpressure
      ab.mem_busy = 1; ab.in_valid = 1; ab.in_data = e[0];
      tick();
      check("t3_ready1", 32'(ab.in_ready), 1);
      check("t3_nowr1", 32'(ab.wr), 0);
      ab.in_data = e[1];
      tick();
      check("t3_full", 32'(ab.in_ready), 0);
      check("t3_nowr2", 32'(ab.wr), 0);
      ab.in_data = e[2];
      tick();
      check("t3_full2", 32'(ab.in_ready), 0);
      check("t3_nowr3", 32'(ab.wr), 0);
      ab.mem_busy = 0;
      tick();
      check_wr("t3_w0", e[0], 8'h10, 8'd1);
      check("t3_ready2", 32'(ab.in_ready), 1);
      tick();
      check_wr("t3_w1", e[1], 8'h11, 8'd2);
      ab.in_valid = 0;
      tick();
      check_wr("t3_w2", e[2], 8'h12, 8'd3);
      ab.in_valid = 1; ab.in_data = e[3];
      tick();
      check("t3_gap", 32'(ab.wr), 0);
      ab.in_valid = 0;
      tick();
      check_wr("t3_w3", e[3], 8'h13, 8'd4);
      check("t3_done", 32'(ab.done), 1);

      // ReLU on/off
      ab.start = 1; tick(); ab.start = 0;
      ab.in_valid = 1; ab.in_data = 32'h807FFF01; ab.relu_en = 1;
      tick();
      ab.relu_en = 0;
      tick();
      check_wr("t2_relu", 32'h007F0001, 8'h10, 8'd1);
      ab.in_valid = 0;
      tick();
      check_wr("t2_norelu", 32'h807FFF01, 8'h11, 8'd2);

      // reset mid-run
      ab.in_valid = 1; ab.in_data = 32'h55555555;
      rst = 1;
      tick();
      rst = 0; ab.in_valid = 0;
      check("t5_wr", 32'(ab.wr), 0);
      check("t5_count", 32'(ab.count), 0);
      check("t5_done", 32'(ab.done), 0);
      check("t5_ready", 32'(ab.in_ready), 0);
      tick();
      check("t5_wr2", 32'(ab.wr), 0);
      ab.start = 1; tick(); ab.start = 0;
      ab.in_valid = 1; ab.in_data = 32'hAABBCCDD;
      tick();
      ab.in_valid = 0;
      tick();
      check_wr("t5_restart", 32'hAABBCCDD, 8'h10, 8'd1);

      // address wrap on the 4-bit instance
      wb.start = 1; tick(); wb.start = 0;
      for (int i = 0; i < 4; i++) begin
         wb.in_valid = 1; wb.in_data = d[i];
         tick();
         if (i > 0) begin
            check("t4_wr", 32'(wb.wr), 1);
            check("t4_addr", 32'(wb.wr_addr), 32'(wrap_addr[i-1]));
            check("t4_data", wb.wr_data, d[i-1]);
         end
      end
      wb.in_valid = 0;
      tick();
      check("t4_wr_last", 32'(wb.wr), 1);
      check("t4_addr_last", 32'(wb.wr_addr), 32'(wrap_addr[3]));
      check("t4_done", 32'(wb.done), 1);
      check("t4_count", 32'(wb.count), 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
